eco_nor_arbiter: RTL

//  Shares one registered per-bit NOR slice unit (y[i] = ~(a[i]|b[i])) between two requesters.

---
 rtl/eco_nor_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/eco_nor_arbiter.sv
// eco_nor_arbiter
// Round-robin sequencer that shares one registered per-bit NOR slice
// (y[i] = ~(a[i] | b[i])) between two valid/ready requesters.
// - A result appears one cycle after it is accepted.
// - A new request can be accepted in the same cycle the held result drains.
// - Each requester has a saturating count of its completed responses.
// Optional build macro: ECO_PATCH_EN. When it is defined, bit PATCH_BIT of the
// result becomes ~a & b instead of the plain NOR.
module eco_nor_arbiter #(
    parameter int WIDTH     = 3,
    parameter int PATCH_BIT = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic [CNT_W-1:0] done0_cnt,
    output logic [CNT_W-1:0] done1_cnt
);

    // The patched bit must exist inside the operand width.
    if ((PATCH_BIT < 0) || (PATCH_BIT >= WIDTH)) begin : g_bad_patch_bit
        $error("eco_nor_arbiter: PATCH_BIT must be within [0, WIDTH-1]");
    end

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Slice function. Every bit is a NOR unless the ECO patch is built in.
    function automatic logic [WIDTH-1:0] slice_f(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] y;
        y = ~(a | b);
`ifdef ECO_PATCH_EN
        y[PATCH_BIT] = ~a[PATCH_BIT] & b[PATCH_BIT];
`endif
        return y;
    endfunction

    // Saturating increment. The count holds at all-ones and does not wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (c == {CNT_W{1'b1}}) begin
            r = c;
        end else begin
            r = c + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             prio_r;       // 1'b0: req0 holds priority, 1'b1: req1
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_id_r;
    logic [CNT_W-1:0] done0_cnt_r;
    logic [CNT_W-1:0] done1_cnt_r;

    logic             can_accept_s;
    logic             acc0_s;
    logic             acc1_s;
    logic             accept_s;
    logic             rsp_hs_s;
    logic [WIDTH-1:0] a_sel_s;
    logic [WIDTH-1:0] b_sel_s;

    assign rsp_valid = (state_r == ST_FULL);
    assign rsp_data  = rsp_data_r;
    assign rsp_id    = rsp_id_r;
    assign done0_cnt = done0_cnt_r;
    assign done1_cnt = done1_cnt_r;

    // The result register can take new data when it is empty or is draining
    // in this same cycle. Neither ready looks at its own valid input.
    assign can_accept_s = ~rsp_valid | rsp_ready;
    assign req0_ready   = can_accept_s & ((prio_r == 1'b0) | ~req1_valid);
    assign req1_ready   = can_accept_s & ((prio_r == 1'b1) | ~req0_valid);

    // The ready terms never let both requesters be accepted in one cycle.
    assign acc0_s   = req0_valid & req0_ready;
    assign acc1_s   = req1_valid & req1_ready;
    assign accept_s = acc0_s | acc1_s;
    assign rsp_hs_s = rsp_valid & rsp_ready;

    // Route the granted requester's operands into the slice.
    always_comb begin
        a_sel_s = req0_a;
        b_sel_s = req0_b;
        if (acc1_s) begin
            a_sel_s = req1_a;
            b_sel_s = req1_b;
        end else begin
            a_sel_s = req0_a;
            b_sel_s = req0_b;
        end
    end

    // Occupancy FSM next state. An accept always leaves the register full.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_nxt_s = ST_FULL;
                end else if (rsp_hs_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Occupancy FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Result register. It captures the slice output on accept and otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data_r <= {WIDTH{1'b0}};
            rsp_id_r   <= 1'b0;
        end else if (accept_s) begin
            rsp_data_r <= slice_f(a_sel_s, b_sel_s);
            rsp_id_r   <= acc1_s;
        end else begin
            rsp_data_r <= rsp_data_r;
            rsp_id_r   <= rsp_id_r;
        end
    end

    // Round-robin pointer. After every grant, priority passes to the other requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_r <= 1'b0;
        end else if (acc0_s) begin
            prio_r <= 1'b1;
        end else if (acc1_s) begin
            prio_r <= 1'b0;
        end else begin
            prio_r <= prio_r;
        end
    end

    // Completion counters. They are credited to the requester that owns the
    // consumed response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done0_cnt_r <= {CNT_W{1'b0}};
            done1_cnt_r <= {CNT_W{1'b0}};
        end else if (rsp_hs_s) begin
            if (rsp_id_r == 1'b0) begin
                done0_cnt_r <= sat_inc(done0_cnt_r);
            end else begin
                done1_cnt_r <= sat_inc(done1_cnt_r);
            end
        end else begin
            done0_cnt_r <= done0_cnt_r;
            done1_cnt_r <= done1_cnt_r;
        end
    end

endmodule
